mem_ctrl: RTL and testbench

- Responder side of the load/store-buffer memory interface, shared with instruction fetch.
- Accepts one word/half/byte request at a time from the LSB (read or write) or from the fetch unit (32-bit read).
- Serialises each request onto the byte-wide RAM/IO bus and returns a one-cycle ok pulse, plus read data for reads.
- Sits between the LSB/IFetch units and the top-level RAM and io_buffer.

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory controller slice.
//   - bus widths and the IO window base address
//   - request width codes (byte / half / word)
//   - controller state encoding and requester ids
//   - norm_width(): maps a raw width code onto 1, 2 or 4 bytes
package mem_ctrl_pkg;

  localparam int          ADDR_WIDTH   = 32;
  localparam int          DATA_WIDTH   = 32;
  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

  localparam logic [2:0] WIDTH_BYTE = 3'd1;
  localparam logic [2:0] WIDTH_HALF = 3'd2;
  localparam logic [2:0] WIDTH_WORD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_LSB = 1'b0,
    REQ_IF  = 1'b1
  } req_t;

  // Anything that is not an explicit byte or half request is a full word.
  function automatic logic [2:0] norm_width(input logic [2:0] w);
    case (w)
      WIDTH_BYTE: norm_width = WIDTH_BYTE;
      WIDTH_HALF: norm_width = WIDTH_HALF;
      default:    norm_width = WIDTH_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder for the LSB / instruction-fetch memory interface.
// Serialises one byte/half/word request at a time onto the byte-wide RAM/IO
// bus and returns a registered one-cycle ok pulse (plus read data).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rdy                    global ready; low freezes every register
//   mispredict             flush pulse; aborts reads, never writes
//   *_from_lsb / *_to_lsb  load/store requester (LSB has priority)
//   *_from_if  / *_to_if   instruction fetch requester (always 4 bytes)
//   io_buffer_full         back-pressure for writes into the IO window
//   mem_din/dout/a/wr      byte-wide RAM/IO bus (RAM has one cycle latency)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_WIDTH,
  parameter int                DATA_W  = DATA_WIDTH,
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              mispredict,
  input  logic              enable_from_lsb,
  input  logic              read_or_write_from_lsb,
  input  logic [ADDR_W-1:0] addr_from_lsb,
  input  logic [DATA_W-1:0] data_from_lsb,
  input  logic [2:0]        width_from_lsb,
  output logic              ok_to_lsb,
  output logic [DATA_W-1:0] data_to_lsb,
  input  logic              enable_from_if,
  input  logic [ADDR_W-1:0] addr_from_if,
  output logic              ok_to_if,
  output logic [DATA_W-1:0] inst_to_if,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [2:0]        nbytes_q, nbytes_d;
  // Read: edges since the first address was issued. Write: index of the byte on the bus.
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              is_io_q, is_io_d;
  logic              rdy_prev_q, rdy_prev_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ok_lsb_q, ok_lsb_d;
  logic              ok_if_q, ok_if_d;
  logic [DATA_W-1:0] data_lsb_q, data_lsb_d;
  logic [DATA_W-1:0] inst_q, inst_d;

  logic [1:0]        rd_idx_s;
  logic [2:0]        wr_nxt_s;

  // The byte arriving now was addressed two edges ago, i.e. index cnt-1.
  assign rd_idx_s = 2'(cnt_q - 3'd1);
  assign wr_nxt_s = cnt_q + 3'd1;

  // Next-state and bus/output computation for the request FSM.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    is_io_d    = is_io_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ok_lsb_d   = ok_lsb_q;
    ok_if_d    = ok_if_q;
    data_lsb_d = data_lsb_q;
    inst_d     = inst_q;
    rdy_prev_d = rdy;

    if (rdy) begin
      ok_lsb_d = 1'b0;
      ok_if_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mispredict) begin
            state_d = ST_IDLE;
          end else if (enable_from_lsb) begin
            req_d    = REQ_LSB;
            nbytes_d = norm_width(width_from_lsb);
            addr_d   = addr_from_lsb;
            wdata_d  = data_from_lsb;
            is_io_d  = (addr_from_lsb >= IO_BASE);
            mem_a_d  = addr_from_lsb;
            cnt_d    = 3'd0;
            rbuf_d   = {DATA_W{1'b0}};
            if (read_or_write_from_lsb) begin
              state_d = ST_READ;
            end else begin
              state_d    = ST_WRITE;
              mem_dout_d = data_from_lsb[7:0];
              mem_wr_d   = !((addr_from_lsb >= IO_BASE) && io_buffer_full);
            end
          end else if (enable_from_if) begin
            req_d    = REQ_IF;
            nbytes_d = WIDTH_WORD;
            addr_d   = addr_from_if;
            is_io_d  = (addr_from_if >= IO_BASE);
            mem_a_d  = addr_from_if;
            cnt_d    = 3'd0;
            rbuf_d   = {DATA_W{1'b0}};
            state_d  = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_READ: begin
          if (mispredict) begin
            state_d  = ST_IDLE;
            mem_wr_d = 1'b0;
            cnt_d    = 3'd0;
          end else if (!rdy_prev_q) begin
            // The RAM pipeline ran on while frozen, so in-flight bytes are stale.
            mem_a_d = addr_q;
            cnt_d   = 3'd0;
            rbuf_d  = {DATA_W{1'b0}};
          end else begin
            cnt_d = wr_nxt_s;
            if (wr_nxt_s < nbytes_q) begin
              mem_a_d = mem_a_q + ADDR_W'(1);
            end else begin
              mem_a_d = mem_a_q;
            end
            if (cnt_q != 3'd0) begin
              rbuf_d[{rd_idx_s, 3'b000} +: 8] = mem_din;
            end else begin
              rbuf_d = rbuf_q;
            end
            if (cnt_q == nbytes_q) begin
              state_d = ST_DONE;
              cnt_d   = 3'd0;
              if (req_q == REQ_LSB) begin
                ok_lsb_d   = 1'b1;
                data_lsb_d = rbuf_d;
              end else begin
                ok_if_d = 1'b1;
                inst_d  = rbuf_d;
              end
            end else begin
              state_d = ST_READ;
            end
          end
        end

        ST_WRITE: begin
          // mem_wr_q high means the byte on the bus is written at this edge.
          if (mem_wr_q) begin
            if (wr_nxt_s == nbytes_q) begin
              mem_wr_d = 1'b0;
              state_d  = ST_DONE;
              ok_lsb_d = 1'b1;
              cnt_d    = 3'd0;
            end else begin
              cnt_d      = wr_nxt_s;
              mem_a_d    = mem_a_q + ADDR_W'(1);
              mem_dout_d = wdata_q[{wr_nxt_s[1:0], 3'b000} +: 8];
              mem_wr_d   = !(is_io_q && io_buffer_full);
            end
          end else begin
            mem_wr_d = !(is_io_q && io_buffer_full);
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d  = ST_IDLE;
          mem_wr_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Register bank; synchronous reset returns to IDLE with quiet outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= REQ_LSB;
      nbytes_q   <= 3'd0;
      cnt_q      <= 3'd0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      rbuf_q     <= {DATA_W{1'b0}};
      is_io_q    <= 1'b0;
      rdy_prev_q <= 1'b1;
      mem_a_q    <= {ADDR_W{1'b0}};
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      ok_lsb_q   <= 1'b0;
      ok_if_q    <= 1'b0;
      data_lsb_q <= {DATA_W{1'b0}};
      inst_q     <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      is_io_q    <= is_io_d;
      rdy_prev_q <= rdy_prev_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ok_lsb_q   <= ok_lsb_d;
      ok_if_q    <= ok_if_d;
      data_lsb_q <= data_lsb_d;
      inst_q     <= inst_d;
    end
  end

  assign ok_to_lsb   = ok_lsb_q;
  assign ok_to_if    = ok_if_q;
  assign data_to_lsb = data_lsb_q;
  assign inst_to_if  = inst_q;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  // A frozen cycle must never commit a byte.
  assign mem_wr      = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM with one-cycle read latency, a byte-array
// reference memory, directed scenarios and randomized load/store/fetch traffic.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, mispredict;
  logic        enable_from_lsb, read_or_write_from_lsb;
  logic [31:0] addr_from_lsb, data_from_lsb;
  logic [2:0]  width_from_lsb;
  logic        ok_to_lsb;
  logic [31:0] data_to_lsb;
  logic        enable_from_if;
  logic [31:0] addr_from_if;
  logic        ok_to_if;
  logic [31:0] inst_to_if;
  logic        io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram       [0:262143];
  logic [7:0]  model_mem [0:262143];
  logic [39:0] wlog[$];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict),
    .enable_from_lsb(enable_from_lsb), .read_or_write_from_lsb(read_or_write_from_lsb),
    .addr_from_lsb(addr_from_lsb), .data_from_lsb(data_from_lsb),
    .width_from_lsb(width_from_lsb), .ok_to_lsb(ok_to_lsb), .data_to_lsb(data_to_lsb),
    .enable_from_if(enable_from_if), .addr_from_if(addr_from_if),
    .ok_to_if(ok_to_if), .inst_to_if(inst_to_if),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM/IO device: synchronous read, write on mem_wr, every write logged.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
      wlog.push_back({mem_a, mem_dout});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input bit is_if, input logic [2:0] w);
    if (is_if) return 4;
    if (w == 3'd1) return 1;
    if (w == 3'd2) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] v;
    logic [31:0] a;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      v = v | (32'(model_mem[a[17:0]]) << (8 * k));
    end
    return v;
  endfunction

  // One complete transaction with optional mispredict pulse / rdy stall.
  task automatic do_op(input bit is_if, input bit is_rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] w,
                       input int mp_at, input int stall_at);
    int          n, edges, exp_lat, extra;
    bit          seen, addr_ok, other;
    logic [31:0] expv, a;
    n     = nbytes(is_if, w);
    expv  = model_read(addr, n);
    extra = (mp_at == 0) ? 1 : 0;
    wlog.delete();
    if (is_if) begin
      enable_from_if = 1'b1;
      addr_from_if   = addr;
    end else begin
      enable_from_lsb        = 1'b1;
      read_or_write_from_lsb = is_rd;
      addr_from_lsb          = addr;
      data_from_lsb          = wd;
      width_from_lsb         = w;
    end
    mispredict = (mp_at == 0);
    edges = 0; seen = 1'b0; addr_ok = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (stall_at < 0 && edges - extra >= 1 && edges - extra <= n &&
          mem_a !== addr + 32'(edges - extra - 1)) addr_ok = 1'b0;
      seen = is_if ? ok_to_if : ok_to_lsb;
      mispredict = (edges == mp_at);
      if (edges == stall_at) begin
        rdy = 1'b0;
        #1 chk("rdy_gate", {63'd0, mem_wr}, 64'd0);
      end
      if (edges == stall_at + 2) rdy = 1'b1;
    end
    mispredict = 1'b0;
    rdy        = 1'b1;
    exp_lat = (is_rd ? n + 2 : n + 1) + extra;
    if (stall_at > 0) exp_lat = exp_lat + (is_rd ? stall_at + 2 : 2);
    chk("ok_seen", {63'd0, seen}, 64'd1);
    chk("latency", 64'(edges), 64'(exp_lat));
    chk("mem_a_seq", {63'd0, addr_ok}, 64'd1);
    other = is_if ? ok_to_lsb : ok_to_if;
    chk("other_ok", {63'd0, other}, 64'd0);
    if (is_rd) begin
      chk(is_if ? "inst" : "rdata", is_if ? 64'(inst_to_if) : 64'(data_to_lsb), 64'(expv));
    end else begin
      chk("wr_count", 64'(wlog.size()), 64'(n));
      for (int k = 0; k < n && k < wlog.size(); k++) begin
        a = addr + 32'(k);
        chk("wr_byte", 64'(wlog[k]), 64'({a, wd[8*k +: 8]}));
      end
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        model_mem[a[17:0]] = wd[8*k +: 8];
      end
    end
    enable_from_if  = 1'b0;
    enable_from_lsb = 1'b0;
    @(posedge clk); #1;
    chk("ok_pulse", {62'd0, ok_to_lsb, ok_to_if}, 64'd0);
  endtask

  initial begin
    int          edges, kind, diffs;
    bit          seen, stray;
    logic [31:0] expv, addr, wd;
    logic [2:0]  w;
    logic [7:0]  b;

    for (int i = 0; i < 262144; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      model_mem[i] = b;
    end
    ram[32'h1000] = 8'h11; ram[32'h1001] = 8'h22; ram[32'h1002] = 8'h33; ram[32'h1003] = 8'h44;
    model_mem[32'h1000] = 8'h11; model_mem[32'h1001] = 8'h22;
    model_mem[32'h1002] = 8'h33; model_mem[32'h1003] = 8'h44;

    rst = 1'b1; rdy = 1'b1; mispredict = 1'b0; io_buffer_full = 1'b0;
    enable_from_lsb = 1'b0; read_or_write_from_lsb = 1'b0; addr_from_lsb = 32'd0;
    data_from_lsb = 32'd0; width_from_lsb = 3'd0; enable_from_if = 1'b0; addr_from_if = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", {data_to_lsb, inst_to_if}, 64'd0);
    chk("reset_bus", {23'd0, mem_a, mem_dout, mem_wr, ok_to_lsb, ok_to_if}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW 0x1000
    do_op(1'b0, 1'b1, 32'h1000, 32'd0, 3'd4, -1, -1);
    chk("lw_1000", 64'(data_to_lsb), 64'h44332211);

    // SH 0x2002
    do_op(1'b0, 1'b0, 32'h2002, 32'hDEADBEEF, 3'd2, -1, -1);
    chk("sh_untouched", 64'(ram[32'h2004]), 64'(model_mem[32'h2004]));

    // Both requesters at once: LSB LB 0x10 first, then fetch 0x0
    expv = model_read(32'h10, 1);
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b1; addr_from_lsb = 32'h10;
    width_from_lsb = 3'd1; enable_from_if = 1'b1; addr_from_if = 32'h0;
    edges = 0; seen = 1'b0; stray = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1; edges++;
      seen = ok_to_lsb;
      if (ok_to_if) stray = 1'b1;
    end
    chk("arb_lsb_ok", {63'd0, seen}, 64'd1);
    chk("arb_lsb_lat", 64'(edges), 64'd3);
    chk("arb_lsb_data", 64'(data_to_lsb), 64'(expv));
    chk("arb_if_wait", {63'd0, stray}, 64'd0);
    enable_from_lsb = 1'b0;
    expv = model_read(32'h0, 4);
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1; edges++;
      seen = ok_to_if;
    end
    chk("arb_if_ok", {63'd0, seen}, 64'd1);
    chk("arb_if_lat", 64'(edges), 64'd7);
    chk("arb_if_inst", 64'(inst_to_if), 64'(expv));
    enable_from_if = 1'b0;
    @(posedge clk); #1;

    // IO store under back-pressure
    wlog.delete();
    io_buffer_full = 1'b1;
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b0; addr_from_lsb = 32'h30000;
    data_from_lsb = 32'h00000041; width_from_lsb = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("io_stall_wr", {62'd0, mem_wr, ok_to_lsb}, 64'd0);
    end
    io_buffer_full = 1'b0;
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1; edges++;
      seen = ok_to_lsb;
    end
    chk("io_ok", {63'd0, seen}, 64'd1);
    chk("io_lat", 64'(edges), 64'd2);
    chk("io_wr_count", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("io_wr", 64'(wlog[0]), 64'({32'h30000, 8'h41}));
    model_mem[32'h30000] = 8'h41;
    enable_from_lsb = 1'b0;
    @(posedge clk); #1;

    // Fetch aborted by mispredict at byte 2, then a fresh fetch of 0x40
    enable_from_if = 1'b1; addr_from_if = 32'h80;
    repeat (3) @(posedge clk);
    #1;
    chk("mp_mem_a", 64'(mem_a), 64'h82);
    mispredict = 1'b1; enable_from_if = 1'b0;
    @(posedge clk); #1;
    mispredict = 1'b0;
    chk("mp_no_ok", {62'd0, ok_to_if, ok_to_lsb}, 64'd0);
    do_op(1'b1, 1'b1, 32'h40, 32'd0, 3'd4, -1, -1);

    // SW survives a mispredict; mispredict pending in IDLE delays acceptance
    do_op(1'b0, 1'b0, 32'h3000, 32'hA5C3_1E77, 3'd4, 2, -1);
    do_op(1'b0, 1'b1, 32'h3000, 32'd0, 3'd4, 0, -1);

    // rdy freeze: read restarts, write resumes
    do_op(1'b0, 1'b1, 32'h1000, 32'd0, 3'd4, -1, 2);
    do_op(1'b0, 1'b0, 32'h5000, 32'h0BAD_F00D, 3'd4, -1, 2);

    // Reset in the middle of a load
    enable_from_lsb = 1'b1; read_or_write_from_lsb = 1'b1; addr_from_lsb = 32'h1000;
    width_from_lsb = 3'd4;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_data", {data_to_lsb, inst_to_if}, 64'd0);
    chk("rst_mid_bus", {23'd0, mem_a, mem_dout, mem_wr, ok_to_lsb, ok_to_if}, 64'd0);
    rst = 1'b0; enable_from_lsb = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ok_to_lsb || ok_to_if) stray = 1'b1;
    end
    chk("rst_no_ok", {63'd0, stray}, 64'd0);

    // Randomized traffic against the reference memory
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      addr = 32'($urandom_range(0, 32'h1FFF8));
      w    = 3'($urandom_range(0, 7));
      wd   = $urandom;
      do_op(kind == 0, kind != 2, addr, wd, w, -1, -1);
    end

    diffs = 0;
    for (int i = 0; i < 262144; i++) begin
      if (ram[i] !== model_mem[i]) diffs++;
    end
    chk("mem_image", 64'(diffs), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
